alu_operand_stage: RTL
======================

# alu_operand_stage

Parametrised operand-select pipeline stage between register-file read and the ALU. It selects operand B from the register file or an extended immediate (ALUSrc), and operand A from the register file. Both register operands are forwarded from the concurrent write-back port. Results are held in a one-entry valid/ready register, and a stalled entry keeps absorbing write-backs so it never goes stale.

## Interface
Parameters:
- DATA_W, 4, operand/ALU datapath width (≥2)
- IMM_W, 4, immediate field width (1 ≤ IMM_W ≤ DATA_W)
- ADDR_W, 2, register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  issue slot carries an instruction
- in_ready  out  1  stage can accept; = !out_valid || out_ready (combinational)
- rs1_addr, rs2_addr  in  ADDR_W  source register addresses
- rs1_data, rs2_data  in  DATA_W  register-file read data
- imm  in  IMM_W  immediate field
- alu_src  in  1  1: B = extended imm; 0: B = forwarded rs2
- imm_sext  in  1  1: sign-extend imm; 0: zero-extend
- flush  in  1  synchronous kill of held and incoming entry
- wb_en  in  1  write-back valid this cycle
- wb_addr  in  ADDR_W  write-back register
- wb_data  in  DATA_W  write-back value
- out_valid  out  1  out_a/out_b valid
- out_ready  in  1  ALU consumes this cycle
- out_a, out_b  out  DATA_W  registered operands
- fwd_a_hit, fwd_b_hit  out  1  registered: operand was replaced by write-back data at capture or while held

## Operation
- Forwarding, capture path: a_sel = (wb_en && wb_addr==rs1_addr) ? wb_data : rs1_data; b_reg likewise with rs2. No special register 0.
- Immediate: IMM_W<DATA_W → upper DATA_W-IMM_W bits = imm[IMM_W-1] if imm_sext, else 0. IMM_W==DATA_W → imm passed unchanged (imm_sext ignored).
- b_sel = alu_src ? ext_imm : b_reg. fwd_b_hit captures 0 when alu_src=1.
- Capture when in_valid && in_ready && !flush. Loads out_a, out_b, fwd hits, and internal copies of rs1_addr, rs2_addr, alu_src. Sets out_valid=1.
- Consume when out_valid && out_ready. If no capture in the same cycle, out_valid→0; out_a/out_b keep their last values.
- Consume and capture in the same cycle: new entry loaded, out_valid stays 1 (full throughput).
- Held refresh: while out_valid && !out_ready && !flush, if wb_en && wb_addr == held rs1 → out_a←wb_data, fwd_a_hit←1. Same for B, only if held alu_src==0. Both may update in one cycle.
- flush: out_valid→0 next edge. Incoming entry dropped even if in_ready=1. Priority: rst > flush > capture/consume > refresh.
- Two states, EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY→FULL on capture.
  - FULL→EMPTY on consume-without-capture or on flush.
  - FULL→FULL on stall or on consume+capture.

## Timing
- Reset (async assert, sampled release): out_valid=0, out_a=0, out_b=0, fwd_a_hit=0, fwd_b_hit=0, held addr/alu_src=0; in_ready=1 while in reset.
- Latency 1 cycle from accepted input to out_valid. Throughput 1 per cycle with out_ready held high.
- in_ready is combinational from out_valid/out_ready; no combinational path from in_* to out_*.
- Write-back in the same cycle as capture is seen via capture forwarding. Write-back in any later cycle while held is seen via refresh. No write-back is missed.
- Reset asserted mid-stall discards the entry immediately (asynchronous); first capture possible on the first edge after release.

## Test plan
- Imm extend, DATA_W=8, IMM_W=4, alu_src=1, imm=4'b1010: imm_sext=1 → out_b=8'hFA; imm_sext=0 → out_b=8'h0A; fwd_b_hit=0.
- Capture forward, defaults: rs1_addr=2, rs1_data=4'h3, wb_en=1, wb_addr=2, wb_data=4'h9 → next cycle out_a=4'h9, fwd_a_hit=1, out_valid=1.
- Stall refresh: entry with rs2_addr=1, alu_src=0, out_b=4'h5 held with out_ready=0. Then wb_en=1, wb_addr=1, wb_data=4'hC → out_b=4'hC, fwd_b_hit=1. Repeat with held alu_src=1 → out_b unchanged.
- Back-to-back: in_valid=1 and out_ready=1 for 4 cycles with operands 1,2,3,4 → out_valid stays 1, out_a sequence 1,2,3,4, in_ready always 1.
- Flush priority: out_valid=1, in_valid=1, out_ready=1, flush=1 → next cycle out_valid=0, new operands not captured.
- Async reset mid-stall: assert rst between edges while out_valid=1 → out_valid, out_a, out_b, fwd hits read 0 before the next clk edge.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ==== alu_operand_stage : operand select + write-back forwarding, one-entry valid/ready hold ====
// ==== rev 1.0                                                                             ====
`default_nettype none

module alu_operand_stage #(
  parameter int DATA_W = 4,
  parameter int IMM_W  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [IMM_W-1:0]  imm,
  input  logic              alu_src,
  input  logic              imm_sext,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   held_rs1;
  logic [ADDR_W-1:0]   held_rs2;
  logic                held_alu_src;

  logic [DATA_W-1:0]   ext_imm;
  logic [DATA_W-1:0]   a_sel;
  logic [DATA_W-1:0]   b_reg;
  logic [DATA_W-1:0]   b_sel;
  logic                hit_a;
  logic                hit_b;
  logic                capture;
  logic                consume;

  generate
    if (IMM_W < DATA_W) begin : g_imm_ext
      assign ext_imm = {{(DATA_W-IMM_W){imm_sext & imm[IMM_W-1]}}, imm};
    end else begin : g_imm_pass
      assign ext_imm = imm;
    end
  endgenerate

  assign hit_a = wb_en && (wb_addr == rs1_addr);
  assign hit_b = wb_en && (wb_addr == rs2_addr);
  assign a_sel = hit_a ? wb_data : rs1_data;
  assign b_reg = hit_b ? wb_data : rs2_data;
  assign b_sel = alu_src ? ext_imm : b_reg;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign capture   = in_valid && in_ready && !flush;
  assign consume   = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      out_a        <= '0;
      out_b        <= '0;
      fwd_a_hit    <= 1'b0;
      fwd_b_hit    <= 1'b0;
      held_rs1     <= '0;
      held_rs2     <= '0;
      held_alu_src <= 1'b0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (capture) begin
      state        <= FULL;
      out_a        <= a_sel;
      out_b        <= b_sel;
      fwd_a_hit    <= hit_a;
      fwd_b_hit    <= hit_b && !alu_src;
      held_rs1     <= rs1_addr;
      held_rs2     <= rs2_addr;
      held_alu_src <= alu_src;
    end else if (consume) begin
      state <= EMPTY;
    end else if (state == FULL) begin
      // Stalled entry keeps tracking write-backs so it never goes stale.
      if (wb_en && (wb_addr == held_rs1)) begin
        out_a     <= wb_data;
        fwd_a_hit <= 1'b1;
      end
      if (wb_en && !held_alu_src && (wb_addr == held_rs2)) begin
        out_b     <= wb_data;
        fwd_b_hit <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
